// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types.
// Holds the divider op encoding (funct3[1:0] of the M-extension divides)
// and the divider FSM state encoding, plus a small decode helper.
package rv32i_types;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  // funct3[0]==0 selects the signed variants (DIV, REM).
  function automatic logic div_op_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  // funct3[1]==1 selects the remainder variants (REM, REMU).
  function automatic logic div_op_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/pipelined_div_unit_if.sv
// Request/response handshake bundle for pipelined_div_unit.
// master : execute-stage issuer (drives req_*, rsp_ready)
// slave  : the divider (drives req_ready, rsp_*)
interface pipelined_div_unit_if
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  div_op_t          req_op;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_dividend, req_divisor, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_dividend, req_divisor, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// rem/quo     : current partial remainder and dividend/quotient shift register
// divisor     : unsigned divisor magnitude
// rem_next    : partial remainder after the trial subtraction
// quo_next    : quotient register shifted left with the new quotient bit
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  // The shifted remainder needs one extra bit: rem < divisor, so
  // {rem, msb} < 2*divisor and may exceed WIDTH bits before the subtract.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign ge       = (shifted >= {1'b0, divisor});
  assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/pipelined_div_unit.sv
// Multicycle RV32M divider (DIV, DIVU, REM, REMU) with RISC-V corner cases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of any in-flight or pending operation
//   bus        : pipelined_div_unit_if.slave (req_* in, rsp_* out, tagged)
//   busy       : high whenever the FSM is not in IDLE
// Latency is WIDTH+2 cycles from acceptance to rsp_valid.
// Build option PIPELINED_DIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and |dividend|<|divisor| skip the iterations and respond in 2 cycles.
module pipelined_div_unit
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipelined_div_unit_if.slave  bus,
  output logic                 busy
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  div_op_t          op_q;
  logic [WIDTH-1:0] dvd_q;     // raw dividend, kept for the div-by-zero remainder
  logic [WIDTH-1:0] dsr_q;     // raw divisor until PREP, magnitude afterwards
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] res_q;
  logic             qsign_q, rsign_q, div0_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             sgn, dvd_neg, dsr_neg, div0, ovf;
  logic [WIDTH-1:0] abs_dvd, abs_dsr;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;

  assign sgn     = div_op_signed(op_q);
  assign dvd_neg = sgn & dvd_q[WIDTH-1];
  assign dsr_neg = sgn & dsr_q[WIDTH-1];
  assign abs_dvd = dvd_neg ? -dvd_q : dvd_q;
  assign abs_dsr = dsr_neg ? -dsr_q : dsr_q;
  assign div0    = (dsr_q == '0);
  assign ovf     = sgn && (dvd_q == MIN_NEG) && (dsr_q == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix = qsign_q ? -quo_q : quo_q;
  assign r_fix = rsign_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = div_op_is_rem(op_q) ? r_fix : q_fix;
    if (div0_q)
      fix_res = div_op_is_rem(op_q) ? dvd_q : '1;
    else if (ovf_q)
      fix_res = div_op_is_rem(op_q) ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DIV_IDLE;
      op_q    <= DIV_OP_DIV;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            dvd_q <= bus.req_dividend;
            dsr_q <= bus.req_divisor;
            tag_q <= bus.req_tag;
            state <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          dsr_q   <= abs_dsr;
          qsign_q <= dvd_neg ^ dsr_neg;
          rsign_q <= dvd_neg;
          div0_q  <= div0;
          ovf_q   <= ovf;
          cnt_q   <= CNT_W'(WIDTH - 1);
`ifdef PIPELINED_DIV_EARLY_OUT_EN
          // Quotient 0 / remainder |dividend| is exact for |a|<|b|; the
          // other two early cases are overridden in FIX anyway.
          if (div0 || ovf || (abs_dvd < abs_dsr)) begin
            quo_q <= '0;
            rem_q <= abs_dvd;
            state <= DIV_FIX;
          end else begin
            quo_q <= abs_dvd;
            rem_q <= '0;
            state <= DIV_ITER;
          end
`else
          quo_q <= abs_dvd;
          rem_q <= '0;
          state <= DIV_ITER;
`endif
        end
        DIV_ITER: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) state <= DIV_FIX;
          else             cnt_q <= cnt_q - 1'b1;
        end
        DIV_FIX: begin
          res_q <= fix_res;
          state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (bus.rsp_ready) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = rst_n && (state == DIV_IDLE);
  assign bus.rsp_valid  = (state == DIV_DONE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_tag    = tag_q;
  assign busy           = (state != DIV_IDLE);
endmodule

// File: tb/tb_pipelined_div_unit.sv
// Self-checking bench for pipelined_div_unit (WIDTH=32, TAG_W=5).
// Directed vector table, handshake/flush/reset sequences, and random
// operations checked against a plain-arithmetic RISC-V reference model.
module tb_pipelined_div_unit;
  import rv32i_types::*;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_div_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

  pipelined_div_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // RISC-V M-extension semantics, straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic is_rem;
    logic is_signed;
    is_rem    = (op == 2'b10) || (op == 2'b11);
    is_signed = (op == 2'b00) || (op == 2'b10);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      if (a == MINV && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : MINV;
      return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem ? a % b : a / b;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef PIPELINED_DIV_EARLY_OUT_EN
    logic        is_signed;
    logic [31:0] ma, mb;
    is_signed = (op == 2'b00) || (op == 2'b10);
    ma = (is_signed && $signed(a) < 0) ? 32'(-a) : a;
    mb = (is_signed && $signed(b) < 0) ? 32'(-b) : b;
    if (b == 32'd0 || (is_signed && a == MINV && b == 32'hFFFF_FFFF) || ma < mb) return 2;
`endif
    return 34;
  endfunction

  // Drive a request and leave once it has been accepted (at posedge+1).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_op       = div_op_t'(op);
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_tag      = tag;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("rsp_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    int lat;
    issue(op, a, b, tag);
    wait_rsp(lat);
    chk({name, "_result"}, bus.rsp_result, exp);
    chk({name, "_tag"}, bus.rsp_tag, tag);
    chk({name, "_latency"}, lat, exp_lat(op, a, b));
    consume();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vt[0]  = '{2'b01, 32'd100,       32'd7,         5'd3,  32'd14};
    vt[1]  = '{2'b11, 32'd100,       32'd7,         5'd3,  32'd2};
    vt[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD};
    vt[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF};
    vt[4]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 5'd4,  32'hFFFF_FFFD};
    vt[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 5'd5,  32'd1};
    vt[6]  = '{2'b00, 32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF};
    vt[7]  = '{2'b11, 32'd5,         32'd0,         5'd7,  32'd5};
    vt[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000};
    vt[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'd0};
    vt[10] = '{2'b01, 32'd3,         32'd10,        5'd10, 32'd0};
    vt[11] = '{2'b10, 32'd3,         32'hFFFF_FFF6, 5'd31, 32'd3};

    bus.req_valid    = 1'b0;
    bus.req_op       = DIV_OP_DIV;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.req_tag      = '0;
    bus.rsp_ready    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", bus.req_ready, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    chk("reset_rsp_tag", bus.rsp_tag, 5'd0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_req_ready", bus.req_ready, 1'b1);

    // Directed vectors
    for (int i = 0; i < 12; i++)
      run_one($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);

    // Backpressure: DONE held with stable outputs
    issue(2'b01, 32'd100, 32'd7, 5'd9);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), bus.rsp_valid, 1'b1);
      chk($sformatf("bp%0d_result", i), bus.rsp_result, 32'd14);
      chk($sformatf("bp%0d_tag", i), bus.rsp_tag, 5'd9);
      chk($sformatf("bp%0d_req_ready", i), bus.req_ready, 1'b0);
    end
    consume();
    chk("bp_release_valid", bus.rsp_valid, 1'b0);
    chk("bp_release_busy", busy, 1'b0);
    chk("bp_release_req_ready", bus.req_ready, 1'b1);
    run_one("after_bp", 2'b00, 32'd1000, 32'd10, 5'd12, 32'd100);

    // Flush in ITER (accept, PREP, then 10 ITER cycles)
    issue(2'b01, 32'd1000, 32'd3, 5'd4);
    repeat (11) @(posedge clk);
    #1;
    chk("pre_flush_busy", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_rsp_valid", bus.rsp_valid, 1'b0);
    chk("flush_req_ready", bus.req_ready, 1'b1);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid) seen++;
      end
      chk("flush_no_late_rsp", seen, 0);
    end
    run_one("after_flush", 2'b01, 32'd9, 32'd3, 5'd13, 32'd3);

    // Flush wins over acceptance in IDLE
    bus.req_valid = 1'b1;
    bus.req_op    = DIV_OP_DIVU;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_vs_accept_busy", busy, 1'b0);

    // Flush wins over the response handshake in DONE
    issue(2'b01, 32'd50, 32'd5, 5'd14);
    wait_rsp(lat);
    flush = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("flush_done_valid", bus.rsp_valid, 1'b0);
    chk("flush_done_busy", busy, 1'b0);

    // Asynchronous reset mid-ITER
    issue(2'b00, 32'd12345, 32'd7, 5'd21);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midreset_rsp_result", bus.rsp_result, 32'd0);
    chk("midreset_rsp_tag", bus.rsp_tag, 5'd0);
    chk("midreset_req_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_release_req_ready", bus.req_ready, 1'b1);
    run_one("after_reset", 2'b11, 32'd77, 32'd10, 5'd22, 32'd7);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = MINV; rb = 32'hFFFF_FFFF; end
        2, 3:    begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
        4:       begin ra = 32'($urandom_range(0, 20)); rb = $urandom; end
        5:       begin ra = $urandom; rb = 32'(-$urandom_range(1, 15)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_one($sformatf("rnd%0d", i), rop, ra, rb, 5'(i), ref_div(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_div_unit.md
# pipelined_div_unit

Parametrised multicycle integer divider for the RV32M execute stage. It implements DIV, DIVU, REM and REMU with RISC-V-exact corner-case results, and uses a valid/ready handshake on both request and response sides. Each request carries a destination tag through to the result. A synchronous flush lets the pipeline kill an in-flight division on a branch mispredict or trap.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥ 4)
- TAG_W, 5, width of the opaque request tag (rd index)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous and active-low; one clock domain
- flush  in  1  synchronous kill of any in-flight or pending operation
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  2  div_op_t: DIV=00, DIVU=01, REM=10, REMU=11 (funct3[1:0])
- req_dividend  in  WIDTH  dividend
- req_divisor  in  WIDTH  divisor
- req_tag  in  TAG_W  tag returned with the result
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
- rsp_tag  out  TAG_W  tag of the request
- busy  out  1  high in any state other than IDLE

## Operation
- **States:** IDLE, PREP, ITER, FIX, DONE.
- **IDLE:** req_ready=1. A request is accepted on an edge where req_valid&&req_ready. On acceptance, register op, operands and tag, then go to PREP.
- **PREP:**
  - Signed ops: take absolute values into WIDTH-bit unsigned registers. 2^(WIDTH-1) is representable, so no overflow.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Flag the special cases: divisor==0, and signed overflow (dividend==most-negative && divisor==−1).
  - Load the iteration counter with WIDTH−1, then go to ITER.
- **ITER:**
  - One restoring step per cycle: shift the {rem,quo} pair left by 1, trial-subtract the divisor from the rem register, and keep the difference if it is non-negative (quotient bit=1).
  - After WIDTH steps (counter==0), go to FIX.
- **FIX:**
  - Apply signs: quotient negated if its sign flag is set; remainder takes the dividend's sign.
  - Special-case overrides:
    - divisor 0: DIV/DIVU→all ones; REM/REMU→dividend.
    - Signed overflow: DIV→most-negative; REM→0.
  - Select the result by op, register it into rsp_result, and go to DONE.
- **DONE:** rsp_valid=1. rsp_result and rsp_tag are held stable until rsp_valid&&rsp_ready, then go to IDLE.
- **flush:** from any state, go to IDLE on the next edge and clear rsp_valid. flush has priority over acceptance and over the response handshake in the same cycle.
- **rst_n low:** immediately forces IDLE, including mid-ITER. Reset values:
  - rsp_valid=0, rsp_result=0, rsp_tag=0, busy=0.
  - req_ready=0 while rst_n is low, and 1 on the first cycle after release.

## Timing
- **Latency:** rsp_valid rises WIDTH+2 cycles after the accepting edge (PREP 1 + ITER WIDTH + FIX 1). For WIDTH=32 this is 34 cycles.
- **Back-to-back:** minimum issue interval is WIDTH+4 cycles (adds the DONE handshake cycle and the return to IDLE).
- **Outputs:** all outputs come from registers or state decode; there is no combinational path from req_* to rsp_*.
- **Backpressure:** rsp_ready low holds DONE indefinitely with outputs stable.
- **Special cases without the early-out macro:** special-case and small-quotient operations take the full latency.

## Configuration
- `PIPELINED_DIV_EARLY_OUT_EN` defined:
  - PREP detects divisor==0, signed overflow, and |dividend|<|divisor|, and goes directly to FIX.
  - For |dividend|<|divisor|: quotient 0, remainder equal to the dividend.
  - These cases reach rsp_valid 2 cycles after acceptance. All other operations are unchanged.
- Undefined: every operation takes exactly WIDTH+2 cycles. Results are bit-identical in both builds.

## Structure
- **div_op_t and the state enum** go in the shared package rv32i_types, next to the existing ALU/branch op types.
- **Sub-module div_step** (WIDTH parameter): purely combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once in ITER. Leaves room for a radix-4 variant that instantiates two.
- **Top-level logic:** the FSM, operand/sign registers, counter, and the FIX result mux live in pipelined_div_unit.

## Test plan
- DIVU 100/7, tag 3 → rsp_result=14, rsp_tag=3, rsp_valid at cycle 34; REMU same operands → 2.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0.
- Hold rsp_ready low 5 cycles in DONE → rsp_valid, result and tag stable, req_ready=0; release → IDLE next cycle, new request accepted.
- Interrupted operations:
  - flush asserted at cycle 10 of ITER → busy=0 next cycle, no rsp_valid; a following DIVU 9/3 → 3.
  - rst_n pulsed mid-ITER → all outputs at reset values.
- With PIPELINED_DIV_EARLY_OUT_EN: DIVU 3/10 → 0 with rsp_valid 2 cycles after accept; REM 3/−10 → 3; DIV 8/0 → 0xFFFFFFFF in 2 cycles.
